aes_prng_masking: RTL and testbench

AES_PRNG_MASKING -- requirements
Module: aes_prng_masking

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_prng_lfsr_step.sv | 21 ++
 rtl/aes_prng_masking.sv | 114 +++++++++++
 tb/tb_aes_prng_masking.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES masking PRNG.
package aes_pkg;

    localparam int unsigned AES_PRNG_WIDTH = 160;

    // Taps for x^160 + x^159 + x^158 + x^157 + 1 (state bits 159..156).
    localparam logic [AES_PRNG_WIDTH-1:0] AES_PRNG_POLY = {4'hf, 156'h0};

    localparam logic [AES_PRNG_WIDTH-1:0] P_PKG =
        160'h9d2c_5680_b6e3_1f47_c0a4_e85b_3397_d21e_74f1_713a;

    typedef enum logic [1:0] {
        IDLE,
        ABSORB,
        FINISH
    } aes_prng_state_e;

endpackage

// File: rtl/aes_prng_lfsr_step.sv
// Unrolled multi-step Fibonacci LFSR advance: shift left, parity of tapped bits enters bit 0.
module aes_prng_lfsr_step #(
    parameter int unsigned      WIDTH = aes_pkg::AES_PRNG_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = aes_pkg::AES_PRNG_POLY,
    parameter int unsigned      STEPS = 32
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] s;

    always_comb begin
        s = cur;
        for (int unsigned i = 0; i < STEPS; i++) begin
            s = {s[WIDTH-2:0], ^(s & POLY)};
        end
        nxt = s;
    end

endmodule

// File: rtl/aes_prng_masking.sv
// Masking-word PRNG: serves OUT_W-bit words per handshake and reseeds by absorbing
// WIDTH/OUT_W entropy words into a rotating LFSR state.
module aes_prng_masking
    import aes_pkg::*;
#(
    parameter int unsigned      WIDTH = AES_PRNG_WIDTH,
    parameter int unsigned      OUT_W = 32,
    parameter logic [WIDTH-1:0] POLY  = AES_PRNG_POLY,
    parameter logic [WIDTH-1:0] SEED  = P_PKG
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_req_i,
    output logic             data_ack_o,
    output logic [OUT_W-1:0] data_o,
    input  logic             reseed_req_i,
    output logic             reseed_ack_o,
    input  logic [OUT_W-1:0] entropy_i,
    input  logic             entropy_valid_i,
    output logic             entropy_ready_o
);

    localparam int unsigned CHUNKS = WIDTH / OUT_W;
    localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNKS - 1);

    if ((OUT_W == 0) || (OUT_W > WIDTH) || ((WIDTH % OUT_W) != 0)) begin : g_bad_width
        $error("aes_prng_masking: WIDTH must be a non-zero multiple of OUT_W");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("aes_prng_masking: SEED must be non-zero");
    end

    aes_prng_state_e  fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] step_nxt;
    logic [WIDTH-1:0] absorb_nxt;

    aes_prng_lfsr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .STEPS (OUT_W)
    ) u_step (
        .cur (state_q),
        .nxt (step_nxt)
    );

    // Absorb rotates the state up by one chunk, folding entropy into the wrapped chunk.
    if (WIDTH == OUT_W) begin : g_absorb_single
        assign absorb_nxt = state_q ^ entropy_i;
    end else begin : g_absorb_rot
        assign absorb_nxt = {state_q[WIDTH-OUT_W-1:0],
                             state_q[WIDTH-1:WIDTH-OUT_W] ^ entropy_i};
    end

    assign data_o = state_q[OUT_W-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            state_q <= SEED;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        fsm_d           = fsm_q;
        cnt_d           = cnt_q;
        state_d         = state_q;
        data_ack_o      = 1'b0;
        reseed_ack_o    = 1'b0;
        entropy_ready_o = 1'b0;

        unique case (fsm_q)
            IDLE: begin
                // A pending reseed starves data requests.
                if (reseed_req_i) begin
                    fsm_d = ABSORB;
                    cnt_d = '0;
                end else if (data_req_i) begin
                    data_ack_o = 1'b1;
                    state_d    = step_nxt;
                end
            end
            ABSORB: begin
                entropy_ready_o = 1'b1;
                if (entropy_valid_i) begin
                    state_d = absorb_nxt;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        fsm_d = FINISH;
                    end
                end
            end
            FINISH: begin
                reseed_ack_o = 1'b1;
                // All-zero is the LFSR lock-up state; recover from it.
                if (state_q == '0) begin
                    state_d = SEED;
                end
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_prng_masking.sv
// Self-checking bench for aes_prng_masking against a word-level reference model.
module tb_aes_prng_masking;
    import aes_pkg::*;

    localparam int unsigned W  = 160;
    localparam int unsigned OW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_req = 1'b0;
    logic          data_ack;
    logic [OW-1:0] data;
    logic          reseed_req = 1'b0;
    logic          reseed_ack;
    logic [OW-1:0] entropy = '0;
    logic          entropy_valid = 1'b0;
    logic          entropy_ready;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] mstate;

    always #5 clk = ~clk;

    aes_prng_masking dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .data_req_i      (data_req),
        .data_ack_o      (data_ack),
        .data_o          (data),
        .reseed_req_i    (reseed_req),
        .reseed_ack_o    (reseed_ack),
        .entropy_i       (entropy),
        .entropy_valid_i (entropy_valid),
        .entropy_ready_o (entropy_ready)
    );

    typedef struct {
        logic req;
        logic exp_ack;
        int   exp_steps;
    } vec_t;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_word(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // n single LFSR steps: shift in the parity of the tapped bits.
    function automatic logic [W-1:0] adv(input logic [W-1:0] s, input int n);
        logic [W-1:0] r;
        r = s;
        for (int i = 0; i < n; i++) begin
            r = (r << 1) | W'($countones(r & AES_PRNG_POLY) % 2);
        end
        return r;
    endfunction

    // Five absorbs rotate a full turn, so word k ends up XORed into chunk 4-k.
    function automatic logic [W-1:0] absorb_model(input logic [W-1:0] s, input logic [OW-1:0] ent [5]);
        logic [W-1:0] r;
        r = s ^ {ent[0], ent[1], ent[2], ent[3], ent[4]};
        if (r == '0) r = P_PKG;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        data_req = 1'b0;
        reseed_req = 1'b0;
        entropy_valid = 1'b0;
        entropy = '0;
        tick();
        tick();
        rst = 1'b0;
        mstate = P_PKG;
        #1;
    endtask

    task automatic do_reseed(input logic [OW-1:0] ent [5], input bit gaps, input logic with_data);
        int cyc;
        int k;
        int ngap;
        bit done;
        logic [OW-1:0] pre;
        pre = mstate[OW-1:0];
        data_req = with_data;
        reseed_req = 1'b1;
        entropy_valid = 1'b0;
        #2;
        chk_bit("rs_data_blocked", data_ack, 1'b0);
        tick();
        chk_word("rs_state_held", data, pre);
        cyc = 1; k = 0; ngap = 0; done = 0;
        while (!done && cyc < 100) begin
            data_req = 1'($urandom % 2);
            if (k < 5 && (!gaps || ($urandom % 3) != 0)) begin
                entropy_valid = 1'b1;
                entropy = ent[k];
            end else begin
                entropy_valid = 1'b0;
                entropy = $urandom;
                if (k < 5) ngap++;
            end
            #2;
            if (reseed_ack) begin
                done = 1;
            end else begin
                chk_bit("rs_ready", entropy_ready, 1'b1);
                chk_bit("rs_busy_ack", data_ack, 1'b0);
                if (entropy_valid) k++;
                tick();
                cyc++;
            end
        end
        chk_word("rs_latency", OW'(cyc), OW'(6 + ngap));
        chk_bit("rs_finish_ready", entropy_ready, 1'b0);
        chk_bit("rs_finish_data_ack", data_ack, 1'b0);
        reseed_req = 1'b0;
        entropy_valid = 1'b0;
        data_req = 1'b0;
        tick();
        mstate = absorb_model(mstate, ent);
        chk_bit("rs_ack_pulse", reseed_ack, 1'b0);
        chk_word("rs_data", data, mstate[OW-1:0]);
    endtask

    initial begin
        vec_t tbl [7];
        logic [OW-1:0] ent [5];
        logic [W-1:0] sd;
        logic [W-1:0] e;
        int guard;
        int k;
        logic r;

        tbl[0] = '{1'b1, 1'b1, 32};
        tbl[1] = '{1'b0, 1'b0, 32};
        tbl[2] = '{1'b1, 1'b1, 64};
        tbl[3] = '{1'b1, 1'b1, 96};
        tbl[4] = '{1'b0, 1'b0, 96};
        tbl[5] = '{1'b0, 1'b0, 96};
        tbl[6] = '{1'b1, 1'b1, 128};

        do_reset();
        #2;
        chk_word("reset_data", data, 32'h74f1713a);
        chk_bit("reset_data_ack", data_ack, 1'b0);
        chk_bit("reset_reseed_ack", reseed_ack, 1'b0);
        chk_bit("reset_ready", entropy_ready, 1'b0);

        // Data handshakes driven from the vector table.
        for (int i = 0; i < 7; i++) begin
            data_req = tbl[i].req;
            #2;
            chk_bit("tbl_ack", data_ack, tbl[i].exp_ack);
            tick();
            e = adv(P_PKG, tbl[i].exp_steps);
            chk_word("tbl_data", data, e[OW-1:0]);
        end
        data_req = 1'b0;

        // Zero entropy with a simultaneous data request: full rotation returns the seed.
        do_reset();
        for (int i = 0; i < 5; i++) ent[i] = '0;
        do_reseed(ent, 1'b0, 1'b1);
        chk_word("zero_reseed_seed", data, 32'h74f1713a);

        // Entropy equal to the seed chunks cancels the state to zero; seed reloaded.
        do_reset();
        sd = P_PKG;
        ent[0] = sd[159:128];
        ent[1] = sd[127:96];
        ent[2] = sd[95:64];
        ent[3] = sd[63:32];
        ent[4] = sd[31:0];
        do_reseed(ent, 1'b0, 1'b0);
        chk_word("lockup_seed", data, 32'h74f1713a);
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        mstate = adv(mstate, 32);
        chk_word("lockup_step", data, mstate[OW-1:0]);

        // Reset in the middle of an absorb with valid gaps.
        reseed_req = 1'b1;
        tick();
        k = 0;
        guard = 0;
        while (k < 2 && guard < 50) begin
            entropy_valid = 1'($urandom % 2);
            entropy = $urandom;
            #2;
            if (entropy_valid) k++;
            tick();
            guard++;
        end
        chk_bit("mid_two_words", 1'(k == 2), 1'b1);
        entropy_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_word("mid_rst_data", data, 32'h74f1713a);
        chk_bit("mid_rst_ready", entropy_ready, 1'b0);
        chk_bit("mid_rst_ack", reseed_ack, 1'b0);
        reseed_req = 1'b0;
        tick();
        rst = 1'b0;
        mstate = P_PKG;
        for (int i = 0; i < 6; i++) begin
            #2;
            chk_bit("mid_no_ack", reseed_ack, 1'b0);
            tick();
        end
        chk_word("mid_idle_data", data, mstate[OW-1:0]);

        // Random mix of data requests and reseeds against the model.
        for (int it = 0; it < 40; it++) begin
            if (($urandom % 5) == 0) begin
                for (int i = 0; i < 5; i++) ent[i] = $urandom;
                do_reseed(ent, 1'b1, 1'($urandom % 2));
            end else begin
                repeat (1 + ($urandom % 4)) begin
                    r = 1'($urandom % 2);
                    data_req = r;
                    #2;
                    chk_bit("rnd_ack", data_ack, r);
                    tick();
                    if (r) mstate = adv(mstate, 32);
                    chk_word("rnd_data", data, mstate[OW-1:0]);
                end
                data_req = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
